// File: rtl/d3_mem_pkg.sv
// Shared types and constants for the main-store cycle sequencer.
package d3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 4;
  localparam int PH_WR      = 4;
  localparam int PH_RD      = 2;
  localparam int PH_LAST    = 10;
  localparam int NUM_PHASES = 10;

  // One-hot decode of a phase index 1..10 onto lines [10:1]
  function automatic logic [10:1] phase_onehot(input logic [3:0] ph);
    logic [10:1] oh;
    oh = '0;
    for (int b = 1; b <= NUM_PHASES; b++) begin
      oh[b] = (ph == 4'(b));
    end
    return oh;
  endfunction

endpackage

// File: rtl/ram_phase_gen.sv
// Phase timebase: sub-counter within a phase, phase index 1..10 and the
// one-hot phase decode. The top gates the decode with its own state.
module ram_phase_gen
  import d3_mem_pkg::*;
#(
  parameter int PHASE_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        enable,
  output logic [10:1] tn,
  output logic        phase_last_clk,
  output logic [3:0]  phase
);

  localparam int SW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  logic [SW-1:0] sub;

  assign phase_last_clk = (sub == SW'(PHASE_LEN - 1));
  assign tn             = phase_onehot(phase);

  // Restart at phase 1 on acceptance, otherwise step the phase each time the sub-counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 4'd1;
      sub   <= '0;
    end else if (start) begin
      phase <= 4'd1;
      sub   <= '0;
    end else if (enable) begin
      if (phase_last_clk) begin
        sub   <= '0;
        phase <= (phase == 4'(PH_LAST)) ? 4'd1 : phase + 4'd1;
      end else begin
        sub <= sub + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_cycle_seq.sv
// Main-store cycle initiator: accepts one request, runs the 10-phase
// memory cycle on tn, and returns the read nibbles with a valid pulse.
module ram_cycle_seq
  import d3_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int PHASE_LEN    = 1,
  parameter int RD_PHASE     = PH_RD,
  parameter int SAMPLE_PHASE = 8
) (
  input  logic          ram_clk,
  input  logic          ram_rst,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic          rvalid,
  output logic [DW-1:0] rdata_x,
  output logic [DW-1:0] rdata_y,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] Data,
  output logic [10:1]   tn,
  output logic          rd_strobe,
  input  logic [DW-1:0] X,
  input  logic [DW-1:0] Y
);

  state_t      state, state_next;
  logic        we_r;
  logic        accept;
  logic        capture;
  logic        phase_last_clk;
  logic [3:0]  phase;
  logic [10:1] tn_raw;

  assign accept  = (state == IDLE) && req;
  assign capture = (state == RUN) && !we_r && (phase == 4'(SAMPLE_PHASE)) && phase_last_clk;

  ram_phase_gen #(
    .PHASE_LEN(PHASE_LEN)
  ) u_phase_gen (
    .clk           (ram_clk),
    .rst           (ram_rst),
    .start         (accept),
    .enable        (state == RUN),
    .tn            (tn_raw),
    .phase_last_clk(phase_last_clk),
    .phase         (phase)
  );

  // State register
  always_ff @(posedge ram_clk) begin
    if (ram_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: leave RUN only after the final clock of phase 10
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = RUN;
      RUN:     if ((phase == 4'(PH_LAST)) && phase_last_clk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: phase lines only in RUN, write phase suppressed for reads
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rvalid    = 1'b0;
    rd_strobe = 1'b0;
    tn        = '0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        tn        = tn_raw;
        if (!we_r) tn[PH_WR] = 1'b0;
        rd_strobe = !we_r && (phase == 4'(RD_PHASE));
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        rvalid = !we_r;
      end
      default: ;
    endcase
  end

  // Request latches held until the next acceptance; read nibbles captured at end of the sample phase
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      Addr    <= '0;
      Data    <= '0;
      we_r    <= 1'b0;
      rdata_x <= '0;
      rdata_y <= '0;
    end else begin
      if (accept) begin
        Addr <= req_addr;
        Data <= req_wdata;
        we_r <= req_we;
      end
      if (capture) begin
        rdata_x <= X;
        rdata_y <= Y;
      end
    end
  end

endmodule
